// File: rtl/div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // Counter must reach WIDTH-1; sized generously to hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Quotient reported on divide-by-zero; sliced to WIDTH at the use site.
    localparam logic [127:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/div_nr_step.sv
// One non-restoring division step: shift in the next dividend bit, then add or
// subtract the divisor depending on the sign of the current partial remainder.
module div_nr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             quo_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    assign shifted  = {rem[WIDTH-1:0], quo_msb};
    assign rem_next = rem[WIDTH] ? (shifted + {1'b0, divisor})
                                 : (shifted - {1'b0, divisor});
    assign q_bit    = ~rem_next[WIDTH];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned integer divider (DIV/DIVU), one quotient bit per
// clock, with divide-by-zero flag and single-cycle done pulse.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    div_state_t       state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic             signed_reg, neg_a_reg, neg_b_reg, zero_reg;
    logic [WIDTH-1:0] q_reg, r_reg;
    logic             done_reg, div_zero_reg;

    logic             divisor_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] r_mag, q_fin, r_fin;

    // Operand conditioning: magnitudes are taken modulo 2^WIDTH, so |MIN| stays exact.
    assign divisor_zero = (divisor == '0);
    assign a_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    div_nr_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .quo_msb  (quo_reg[WIDTH-1]),
        .divisor  (dvs_reg),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Final remainder correction only needs the low WIDTH bits: the result lies in [0, divisor).
    assign r_mag = rem_reg[WIDTH] ? (rem_reg[WIDTH-1:0] + dvs_reg) : rem_reg[WIDTH-1:0];
    assign q_fin = (signed_reg && (neg_a_reg ^ neg_b_reg)) ? -quo_reg : quo_reg;
    assign r_fin = (signed_reg && neg_a_reg) ? -r_mag : r_mag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = divisor_zero ? FIX : ITER;
            ITER:    if (cnt_reg == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            dvs_reg      <= '0;
            signed_reg   <= 1'b0;
            neg_a_reg    <= 1'b0;
            neg_b_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            q_reg        <= '0;
            r_reg        <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        signed_reg <= is_signed;
                        neg_a_reg  <= dividend[WIDTH-1];
                        neg_b_reg  <= divisor[WIDTH-1];
                        rem_reg    <= '0;
                        cnt_reg    <= '0;
                        // On divide-by-zero the raw dividend rides in quo_reg to become r.
                        quo_reg    <= divisor_zero ? dividend : a_mag;
                        dvs_reg    <= b_mag;
                        zero_reg   <= divisor_zero;
                    end
                end
                ITER: begin
                    rem_reg <= step_rem;
                    quo_reg <= {quo_reg[WIDTH-2:0], step_q};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                FIX: begin
                    done_reg     <= 1'b1;
                    div_zero_reg <= zero_reg;
                    if (zero_reg) begin
                        q_reg <= DZ_QUOTIENT[WIDTH-1:0];
                        r_reg <= quo_reg;
                    end else begin
                        q_reg <= q_fin;
                        r_reg <= r_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q        = q_reg;
    assign r        = r_reg;
    assign done     = done_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model.
module tb_div_seq;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic        start32 = 1'b0, sgn32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, q32, r32;
    logic        busy32, done32, dz32;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, q8, r8;
    logic        busy8, done8, dz8;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    div_seq #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .is_signed(sgn32),
        .dividend(a32), .divisor(b32), .q(q32), .r(r32),
        .busy(busy32), .done(done32), .div_zero(dz32)
    );

    div_seq #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .is_signed(sgn8),
        .dividend(a8), .divisor(b8), .q(q8), .r(r8),
        .busy(busy8), .done(done8), .div_zero(dz8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on sign-extended or zero-extended values.
    function automatic void ref_div(input int w, input bit s, input logic [31:0] a_in,
                                    input logic [31:0] b_in, output logic [31:0] eq,
                                    output logic [31:0] er, output bit ez);
        logic [31:0] mask;
        logic [31:0] a, b;
        longint sa, sb;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        a = a_in & mask;
        b = b_in & mask;
        ez = (b == 0);
        if (ez) begin
            eq = mask;
            er = a;
        end else if (s) begin
            sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
            sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
            eq = 32'(sa / sb) & mask;
            er = 32'(sa % sb) & mask;
        end else begin
            eq = a / b;
            er = a % b;
        end
    endfunction

    task automatic drive(input int w, input bit st, input bit s, input logic [31:0] a,
                         input logic [31:0] b);
        if (w == 32) begin
            start32 = st; sgn32 = s; a32 = a; b32 = b;
        end else begin
            start8 = st; sgn8 = s; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    task automatic sample(input int w, output logic [31:0] gq, output logic [31:0] gr,
                          output logic gb, output logic gd, output logic gz);
        if (w == 32) begin
            gq = q32; gr = r32; gb = busy32; gd = done32; gz = dz32;
        end else begin
            gq = {24'h0, q8}; gr = {24'h0, r8}; gb = busy8; gd = done8; gz = dz8;
        end
    endtask

    // One division: accept, scramble operands, optionally poke start while busy, await done.
    task automatic run_op(input int w, input bit s, input logic [31:0] a, input logic [31:0] b,
                          input int poke);
        logic [31:0] eq, er, gq, gr;
        logic gb, gd, gz;
        bit ez, seen;
        int cyc, busy_n, exp_lat;
        ref_div(w, s, a, b, eq, er, ez);
        exp_lat = ez ? 1 : w + 1;
        drive(w, 1'b1, s, a, b);
        @(posedge clock); #1;
        drive(w, 1'b0, ~s, ~a, ~b);
        sample(w, gq, gr, gb, gd, gz);
        busy_n = gb ? 1 : 0;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            if (cyc == poke) drive(w, 1'b1, ~s, a + 32'd5, b | 32'd1);
            if (cyc == poke + 1) drive(w, 1'b0, s, a, b);
            @(posedge clock); #1;
            cyc++;
            sample(w, gq, gr, gb, gd, gz);
            if (gd) seen = 1;
            else if (gb) busy_n++;
        end
        check("latency", cyc, exp_lat);
        check("busy_cycles", busy_n, exp_lat);
        check("busy_at_done", {31'h0, gb}, 32'h0);
        check("q", gq, eq);
        check("r", gr, er);
        check("div_zero", {31'h0, gz}, {31'h0, ez});
        $display("op w=%0d s=%0d a=%0h b=%0h -> q=%0h r=%0h dz=%0d lat=%0d",
                 w, s, a, b, gq, gr, gz, cyc);
    endtask

    initial begin
        logic [31:0] gq, gr;
        logic gb, gd, gz;
        int t, t1, t2, ndone, dcount;

        repeat (3) @(posedge clock);
        #1;
        sample(32, gq, gr, gb, gd, gz);
        check("rst_q", gq, 0);
        check("rst_r", gr, 0);
        check("rst_busy", {31'h0, gb}, 0);
        check("rst_done", {31'h0, gd}, 0);
        check("rst_dz", {31'h0, gz}, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        run_op(32, 1'b0, 32'd100, 32'd7, -1);
        check("q_100_7", q32, 32'd14);
        check("r_100_7", r32, 32'd2);
        run_op(32, 1'b1, -32'sd7, 32'd2, -1);
        check("q_m7_2", q32, -32'sd3);
        check("r_m7_2", r32, -32'sd1);
        run_op(32, 1'b1, 32'd7, -32'sd2, -1);
        run_op(32, 1'b1, -32'sd7, -32'sd2, -1);
        run_op(32, 1'b0, 32'hFFFF_FFFF, 32'd2, -1);
        run_op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("q_min_m1", q32, 32'h8000_0000);
        run_op(32, 1'b0, 32'd5, 32'd9, -1);
        run_op(32, 1'b1, 32'd1234, 32'd0, -1);
        check("dz_q", q32, 32'hFFFF_FFFF);
        run_op(32, 1'b0, 32'd100, 32'd7, -1);
        run_op(32, 1'b0, 32'd1000, 32'd3, 5);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] rb;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            run_op(32, 1'($urandom_range(0, 1)), $urandom, rb, -1);
        end

        // Start held high: two back-to-back results.
        drive(32, 1'b1, 1'b0, 32'd1000, 32'd7);
        t = 0; t1 = -1; t2 = -1; ndone = 0;
        while (ndone < 2 && t < 200) begin
            @(posedge clock); #1;
            t++;
            if (done32) begin
                ndone++;
                check("b2b_q", q32, 32'd142);
                check("b2b_r", r32, 32'd6);
                if (ndone == 1) t1 = t;
                else begin
                    t2 = t;
                    start32 = 1'b0;
                end
            end
        end
        start32 = 1'b0;
        check("b2b_gap", t2 - t1, 34);
        @(posedge clock); #1;
        check("done_pulse", {31'h0, done32}, 0);
        check("hold_q", q32, 32'd142);
        check("idle_busy", {31'h0, busy32}, 0);

        // Reset during iteration 10.
        drive(32, 1'b1, 1'b1, -32'sd12345, 32'd77);
        @(posedge clock); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_q", q32, 0);
        check("mid_rst_r", r32, 0);
        check("mid_rst_busy", {31'h0, busy32}, 0);
        check("mid_rst_done", {31'h0, done32}, 0);
        check("mid_rst_dz", {31'h0, dz32}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (done32 || busy32) dcount++;
        end
        check("no_done_after_rst", dcount, 0);

        // WIDTH=8: full divisor sweeps on key dividends plus random pairs.
        for (int bv = 0; bv < 256; bv++) begin
            run_op(8, 1'b1, 32'h80, bv, -1);
            run_op(8, 1'b0, 32'hFF, bv, -1);
        end
        for (int av = 0; av < 256; av++) begin
            run_op(8, 1'b1, av, 32'hFF, -1);
        end
        for (int i = 0; i < 2000; i++) begin
            run_op(8, 1'($urandom_range(0, 1)), $urandom & 32'hFF, $urandom & 32'hFF, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
